unidad_de_control_multiciclo: RTL and testbench
===============================================

Name: unidad_de_control_multiciclo

Overview:
- Parametrised multi-cycle successor to the single-cycle control unit.
- Accepts one instruction word per valid/accept handshake and sequences it through DECODE, EXEC, optional MEM and WB states.
- Drives the register-bank, ALU, memory and jump controls, and flags illegal opcodes and memory timeouts.
- Sits between the instruction fetch stage and the datapath (register bank, ALU, data memory).

Parameters:
- OPCODE_W, 3: opcode width; codes >= 8 are illegal.
- REG_ADDR_W, 3: register address width; operand bus is 2*REG_ADDR_W wide.
- FLAG_W, 3: number of ALU flags.
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for i_Mem_lista.

Ports:
- i_Timming  in  1  clock, rising edge.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Instr_valida  in  1  fetch presents a valid instruction.
- i_Operation_code  in  OPCODE_W  opcode.
- i_Operandos  in  2*REG_ADDR_W  [2R-1:R] = RX/destination field, [R-1:0] = RY/condition field.
- i_Bandera  in  FLAG_W  ALU flags, sampled in EXEC.
- i_Mem_lista  in  1  data memory completed the access.
- o_Instr_aceptada  out  1  handshake accept.
- o_Control_RX  out  REG_ADDR_W  read port X address.
- o_Control_RY  out  REG_ADDR_W  read port Y address.
- o_Seleccion_registro_escritura  out  REG_ADDR_W  write address.
- o_Selector_de_entrada_a_registros  out  2  00 ALU, 01 memory, 10 RY passthrough.
- o_Senal_de_control  out  3  ALU op.
- o_Lectura_escritura  out  2  00 idle, 01 read, 10 write.
- o_Hab  out  1  register write enable.
- o_Senal_de_salto  out  1  jump taken.
- o_Estado  out  3  current state, for debug.
- o_Error  out  1  sticky error.

Behaviour:
- Reset: while i_Rst=0, the state is IDLE, latched instruction, counter and o_Error are 0, and every output is 0.
  - A reset asserted mid-instruction aborts the instruction immediately; no partial write completes.
- Opcode map (low 3 bits, upper bits zero):
  - 000 ADD, 001 SUB, 010 AND, 011 OR: o_Senal_de_control = opcode, select 00, WB.
  - 100 LOAD: read; write address = RX, memory address from RY; select 01.
  - 101 STORE: write; no WB.
  - 110 MOV: select 10, RX <- RY.
  - 111 JMP: no WB.
- IDLE:
  - o_Instr_aceptada = i_Instr_valida, combinationally.
  - On an edge with valid=1, latch opcode and operands, then go to DECODE.
  - The accept signal is never high outside IDLE.
- DECODE (1 cycle):
  - o_Control_RX/RY are driven from the latched fields and stay valid through WB.
  - Illegal opcode: set o_Error, go to IDLE, no control asserted.
  - Otherwise go to EXEC.
- EXEC (1 cycle):
  - ALU ops drive o_Senal_de_control.
  - JMP: taken if RY==0, or if RY in 1..FLAG_W and i_Bandera[RY-1]=1. When taken, o_Senal_de_salto=1 for this cycle only. RY > FLAG_W means not taken. Next state IDLE.
  - LOAD/STORE go to MEM; ALU ops and MOV go to WB.
- MEM:
  - o_Lectura_escritura is held at 01 or 10 and the counter increments each cycle.
  - If i_Mem_lista=1: LOAD goes to WB, STORE goes to IDLE, and the counter clears.
  - If the counter reaches MEM_TIMEOUT without ready: set o_Error, go to IDLE, no WB.
  - i_Mem_lista arriving on the timeout cycle counts as success.
- WB (1 cycle):
  - o_Hab=1, o_Seleccion_registro_escritura = RX, and the selector is held. Next state IDLE.
- Latency from accept edge:
  - ALU/MOV: o_Hab high in the 3rd cycle after accept.
  - LOAD: o_Hab high 1 cycle after i_Mem_lista.
  - Throughput: ALU/MOV take 4 cycles per instruction including IDLE.
- o_Error stays set until reset; the unit keeps executing after an error.
- o_Estado encoding: IDLE 0, DECODE 1, EXEC 2, MEM 3, WB 4.

Decomposition:
- Package unidad_de_control_pkg holds:
  - opcode constants;
  - state encoding;
  - lectura_escritura and selector encodings;
  - ALU op codes.
- Sub-module decodificador_de_instruccion: combinational; latched opcode to control word (ALU op, selector, uses_mem, rw, writes_back, is_jump, illegal).
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset, then valid with ADD (000) and operandos 6'b011101 -> accept for 1 cycle; RX=3, RY=5 from DECODE; o_Senal_de_control=000 in EXEC; o_Hab=1 with write address 3 in the 3rd cycle after accept.
- LOAD with operandos 6'b010001, i_Mem_lista asserted after 4 wait cycles -> o_Lectura_escritura=01 for 5 cycles; o_Hab=1 with select 01 the next cycle.
- JMP with bandera 3'b000 and RY=1 -> no o_Senal_de_salto. JMP with bandera 3'b001 and RY=1 -> salto=1 for exactly 1 cycle. JMP with RY=0 -> always taken.
- STORE with i_Mem_lista never asserted -> o_Error rises after 15 MEM cycles; no o_Hab; next instruction still accepted.
- OPCODE_W=4, opcode 4'b1010 -> o_Error=1 after DECODE; no o_Hab or memory access. Reset during MEM of a LOAD -> all outputs 0 immediately; no WB afterwards.

Source files
------------

// File: rtl/unidad_de_control_multiciclo_pkg.sv
// Shared definitions for the multi-cycle control unit.
//   - opcode constants (low 3 bits of the opcode field)
//   - FSM state encoding (also exported on o_Estado)
//   - memory read/write and register-input selector encodings
//   - ALU operation codes
//   - control word produced by the instruction decoder
package unidad_de_control_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_LOAD  = 3'b100;
   localparam logic [2:0] OP_STORE = 3'b101;
   localparam logic [2:0] OP_MOV   = 3'b110;
   localparam logic [2:0] OP_JMP   = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } estado_t;

   localparam logic [1:0] LE_IDLE  = 2'b00;
   localparam logic [1:0] LE_READ  = 2'b01;
   localparam logic [1:0] LE_WRITE = 2'b10;

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_RY  = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_NOP = 3'b000;

   typedef struct packed {
      logic [2:0] alu_op;
      logic [1:0] sel;
      logic       uses_mem;
      logic [1:0] rw;
      logic       writes_back;
      logic       is_jump;
      logic       illegal;
   } ctrl_word_t;

endpackage

// File: rtl/unidad_de_control_multiciclo_decodificador.sv
// Combinational instruction decoder: latched opcode -> control word.
// Ports:
//   i_Opcode  in   OPCODE_W  latched opcode
//   o_Ctrl    out  ctrl_word_t  ALU op, selector, memory use/direction,
//                               write-back, jump and illegal flags
module decodificador_de_instruccion
   import unidad_de_control_pkg::*;
#(
   parameter int OPCODE_W = 3
) (
   input  logic [OPCODE_W-1:0] i_Opcode,
   output ctrl_word_t          o_Ctrl
);

   // Any set bit above the low three makes the code >= 8, i.e. illegal.
   logic w_upper;

   generate
      if (OPCODE_W > 3) begin : g_upper
         assign w_upper = |i_Opcode[OPCODE_W-1:3];
      end else begin : g_no_upper
         assign w_upper = 1'b0;
      end
   endgenerate

   always_comb begin
      o_Ctrl = '0;
      if (w_upper) begin
         o_Ctrl.illegal = 1'b1;
      end else begin
         case (i_Opcode[2:0])
            OP_ADD: begin
               o_Ctrl.alu_op      = ALU_ADD;
               o_Ctrl.sel         = SEL_ALU;
               o_Ctrl.writes_back = 1'b1;
            end
            OP_SUB: begin
               o_Ctrl.alu_op      = ALU_SUB;
               o_Ctrl.sel         = SEL_ALU;
               o_Ctrl.writes_back = 1'b1;
            end
            OP_AND: begin
               o_Ctrl.alu_op      = ALU_AND;
               o_Ctrl.sel         = SEL_ALU;
               o_Ctrl.writes_back = 1'b1;
            end
            OP_OR: begin
               o_Ctrl.alu_op      = ALU_OR;
               o_Ctrl.sel         = SEL_ALU;
               o_Ctrl.writes_back = 1'b1;
            end
            OP_LOAD: begin
               o_Ctrl.alu_op      = ALU_NOP;
               o_Ctrl.sel         = SEL_MEM;
               o_Ctrl.uses_mem    = 1'b1;
               o_Ctrl.rw          = LE_READ;
               o_Ctrl.writes_back = 1'b1;
            end
            OP_STORE: begin
               o_Ctrl.alu_op   = ALU_NOP;
               o_Ctrl.uses_mem = 1'b1;
               o_Ctrl.rw       = LE_WRITE;
            end
            OP_MOV: begin
               o_Ctrl.alu_op      = ALU_NOP;
               o_Ctrl.sel         = SEL_RY;
               o_Ctrl.writes_back = 1'b1;
            end
            OP_JMP: begin
               o_Ctrl.alu_op  = ALU_NOP;
               o_Ctrl.is_jump = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/unidad_de_control_multiciclo.sv
// Multi-cycle control unit: IDLE -> DECODE -> EXEC -> [MEM] -> WB.
// Ports:
//   i_Timming                          clock (rising edge)
//   i_Rst                              async reset, active low
//   i_Instr_valida / o_Instr_aceptada  fetch handshake (accept only in IDLE)
//   i_Operation_code                   opcode
//   i_Operandos                        {RX/dest, RY/condition}
//   i_Bandera                          ALU flags, looked at in EXEC for JMP
//   i_Mem_lista                        data memory finished the access
//   o_Control_RX / o_Control_RY        read addresses, DECODE..WB
//   o_Seleccion_registro_escritura     write address (RX) in WB
//   o_Selector_de_entrada_a_registros  00 ALU, 01 memory, 10 RY
//   o_Senal_de_control                 ALU op (EXEC and WB)
//   o_Lectura_escritura                00 idle, 01 read, 10 write (MEM)
//   o_Hab                              register write enable (WB)
//   o_Senal_de_salto                   jump taken (EXEC, one cycle)
//   o_Estado                           current state
//   o_Error                            sticky: illegal opcode or memory timeout
module unidad_de_control_multiciclo
   import unidad_de_control_pkg::*;
#(
   parameter int OPCODE_W    = 3,
   parameter int REG_ADDR_W  = 3,
   parameter int FLAG_W      = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                    i_Timming,
   input  logic                    i_Rst,
   input  logic                    i_Instr_valida,
   input  logic [OPCODE_W-1:0]     i_Operation_code,
   input  logic [2*REG_ADDR_W-1:0] i_Operandos,
   input  logic [FLAG_W-1:0]       i_Bandera,
   input  logic                    i_Mem_lista,
   output logic                    o_Instr_aceptada,
   output logic [REG_ADDR_W-1:0]   o_Control_RX,
   output logic [REG_ADDR_W-1:0]   o_Control_RY,
   output logic [REG_ADDR_W-1:0]   o_Seleccion_registro_escritura,
   output logic [1:0]              o_Selector_de_entrada_a_registros,
   output logic [2:0]              o_Senal_de_control,
   output logic [1:0]              o_Lectura_escritura,
   output logic                    o_Hab,
   output logic                    o_Senal_de_salto,
   output logic [2:0]              o_Estado,
   output logic                    o_Error
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   estado_t                 r_estado, w_siguiente;
   logic [OPCODE_W-1:0]     r_opcode;
   logic [REG_ADDR_W-1:0]   r_rx, r_ry;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_error;

   ctrl_word_t              w_ctrl;
   logic                    w_acepta;
   logic                    w_timeout;
   logic                    w_salto_cond;
   logic                    w_set_error;

   decodificador_de_instruccion #(
      .OPCODE_W (OPCODE_W)
   ) u_deco (
      .i_Opcode (r_opcode),
      .o_Ctrl   (w_ctrl)
   );

   assign w_acepta  = (r_estado == ST_IDLE) && i_Instr_valida;

   // r_cnt holds the number of MEM cycles already spent without ready, so
   // the MEM_TIMEOUT-th cycle is the one where it equals MEM_TIMEOUT-1.
   assign w_timeout = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

   // Jump taken on RY==0 (unconditional) or when the flag selected by RY
   // (1-based) is set; RY beyond the flag count never matches.
   always_comb begin
      w_salto_cond = (r_ry == '0);
      for (int k = 0; k < FLAG_W; k++) begin
         if ((int'(r_ry) == k + 1) && i_Bandera[k]) w_salto_cond = 1'b1;
      end
   end

   always_ff @(posedge i_Timming or negedge i_Rst) begin
      if (!i_Rst) begin
         r_estado <= ST_IDLE;
         r_opcode <= '0;
         r_rx     <= '0;
         r_ry     <= '0;
         r_cnt    <= '0;
         r_error  <= 1'b0;
      end else begin
         r_estado <= w_siguiente;
         if (w_acepta) begin
            r_opcode <= i_Operation_code;
            r_rx     <= i_Operandos[2*REG_ADDR_W-1:REG_ADDR_W];
            r_ry     <= i_Operandos[REG_ADDR_W-1:0];
         end
         if ((r_estado == ST_MEM) && !i_Mem_lista && !w_timeout)
            r_cnt <= r_cnt + CNT_W'(1);
         else
            r_cnt <= '0;
         if (w_set_error) r_error <= 1'b1;
      end
   end

   always_comb begin
      w_siguiente                       = r_estado;
      w_set_error                       = 1'b0;
      o_Instr_aceptada                  = 1'b0;
      o_Control_RX                      = '0;
      o_Control_RY                      = '0;
      o_Seleccion_registro_escritura    = '0;
      o_Selector_de_entrada_a_registros = SEL_ALU;
      o_Senal_de_control                = ALU_NOP;
      o_Lectura_escritura               = LE_IDLE;
      o_Hab                             = 1'b0;
      o_Senal_de_salto                  = 1'b0;

      case (r_estado)
         ST_IDLE: begin
            // Gated by reset so nothing is accepted while reset is held.
            o_Instr_aceptada = i_Instr_valida & i_Rst;
            if (i_Instr_valida) w_siguiente = ST_DECODE;
         end
         ST_DECODE: begin
            o_Control_RX = r_rx;
            o_Control_RY = r_ry;
            if (w_ctrl.illegal) begin
               w_set_error = 1'b1;
               w_siguiente = ST_IDLE;
            end else begin
               w_siguiente = ST_EXEC;
            end
         end
         ST_EXEC: begin
            o_Control_RX                      = r_rx;
            o_Control_RY                      = r_ry;
            o_Senal_de_control                = w_ctrl.alu_op;
            o_Selector_de_entrada_a_registros = w_ctrl.sel;
            if (w_ctrl.is_jump) begin
               o_Senal_de_salto = w_salto_cond;
               w_siguiente      = ST_IDLE;
            end else if (w_ctrl.uses_mem) begin
               w_siguiente = ST_MEM;
            end else begin
               w_siguiente = ST_WB;
            end
         end
         ST_MEM: begin
            o_Control_RX                      = r_rx;
            o_Control_RY                      = r_ry;
            o_Selector_de_entrada_a_registros = w_ctrl.sel;
            o_Lectura_escritura               = w_ctrl.rw;
            // Ready wins over timeout when both land on the same cycle.
            if (i_Mem_lista) begin
               w_siguiente = w_ctrl.writes_back ? ST_WB : ST_IDLE;
            end else if (w_timeout) begin
               w_set_error = 1'b1;
               w_siguiente = ST_IDLE;
            end
         end
         ST_WB: begin
            o_Control_RX                      = r_rx;
            o_Control_RY                      = r_ry;
            o_Selector_de_entrada_a_registros = w_ctrl.sel;
            o_Senal_de_control                = w_ctrl.alu_op;
            o_Seleccion_registro_escritura    = r_rx;
            o_Hab                             = 1'b1;
            w_siguiente                       = ST_IDLE;
         end
         default: w_siguiente = ST_IDLE;
      endcase
   end

   assign o_Estado = r_estado;
   assign o_Error  = r_error;

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
module tb_unidad_de_control_multiciclo;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid, valid2;
   logic [2:0] op;
   logic [3:0] op2;
   logic [5:0] ops;
   logic [2:0] band;
   logic       mem_lista;

   logic       acc, hab, salto, err;
   logic [2:0] rx, ry, waddr, ctl, est;
   logic [1:0] sel, le;

   logic       acc2, hab2, salto2, err2;
   logic [2:0] rx2, ry2, waddr2, ctl2, est2;
   logic [1:0] sel2, le2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   unidad_de_control_multiciclo dut (
      .i_Timming(clk), .i_Rst(rst), .i_Instr_valida(valid),
      .i_Operation_code(op), .i_Operandos(ops), .i_Bandera(band),
      .i_Mem_lista(mem_lista), .o_Instr_aceptada(acc),
      .o_Control_RX(rx), .o_Control_RY(ry),
      .o_Seleccion_registro_escritura(waddr),
      .o_Selector_de_entrada_a_registros(sel),
      .o_Senal_de_control(ctl), .o_Lectura_escritura(le), .o_Hab(hab),
      .o_Senal_de_salto(salto), .o_Estado(est), .o_Error(err)
   );

   unidad_de_control_multiciclo #(.OPCODE_W(4)) dut2 (
      .i_Timming(clk), .i_Rst(rst), .i_Instr_valida(valid2),
      .i_Operation_code(op2), .i_Operandos(ops), .i_Bandera(band),
      .i_Mem_lista(mem_lista), .o_Instr_aceptada(acc2),
      .o_Control_RX(rx2), .o_Control_RY(ry2),
      .o_Seleccion_registro_escritura(waddr2),
      .o_Selector_de_entrada_a_registros(sel2),
      .o_Senal_de_control(ctl2), .o_Lectura_escritura(le2), .o_Hab(hab2),
      .o_Senal_de_salto(salto2), .o_Estado(est2), .o_Error(err2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] op;
      logic [5:0] ops;
      logic [2:0] band;
      logic       jmp;
      logic [2:0] rx, ry, ctl;
      logic [1:0] sel;
      logic       salto;
   } vec_t;

   vec_t tabla[10];

   // Runs a non-memory instruction from IDLE; starts and ends just after a negedge.
   task automatic run_vec(input vec_t v, input int i);
      op = v.op; ops = v.ops; band = v.band; valid = 1'b1;
      #1;
      chk($sformatf("v%0d.idle_est", i), est, 0);
      chk($sformatf("v%0d.accept", i), acc, 1);
      @(negedge clk);
      chk($sformatf("v%0d.dec_est", i), est, 1);
      chk($sformatf("v%0d.dec_acc", i), acc, 0);
      chk($sformatf("v%0d.rx", i), rx, v.rx);
      chk($sformatf("v%0d.ry", i), ry, v.ry);
      chk($sformatf("v%0d.dec_salto", i), salto, 0);
      valid = 1'b0; op = 3'b000; ops = 6'b0;
      @(negedge clk);
      chk($sformatf("v%0d.exe_est", i), est, 2);
      chk($sformatf("v%0d.ctl", i), ctl, v.ctl);
      chk($sformatf("v%0d.salto", i), salto, v.salto);
      chk($sformatf("v%0d.exe_hab", i), hab, 0);
      @(negedge clk);
      if (v.jmp) begin
         chk($sformatf("v%0d.j_est", i), est, 0);
         chk($sformatf("v%0d.j_salto_off", i), salto, 0);
         chk($sformatf("v%0d.j_hab", i), hab, 0);
      end else begin
         chk($sformatf("v%0d.wb_est", i), est, 4);
         chk($sformatf("v%0d.wb_hab", i), hab, 1);
         chk($sformatf("v%0d.wb_addr", i), waddr, v.rx);
         chk($sformatf("v%0d.wb_sel", i), sel, v.sel);
         @(negedge clk);
         chk($sformatf("v%0d.end_est", i), est, 0);
         chk($sformatf("v%0d.end_hab", i), hab, 0);
      end
      band = 3'b000;
   endtask

   // Issue a memory instruction and walk to the first MEM cycle.
   task automatic to_mem(input logic [2:0] o, input logic [5:0] oa);
      op = o; ops = oa; valid = 1'b1;
      #1 chk("mem.accept", acc, 1);
      @(negedge clk);
      valid = 1'b0;
      chk("mem.dec_le", le, 0);
      @(negedge clk);
      chk("mem.exe_le", le, 0);
      @(negedge clk);
   endtask

   initial begin
      //          op      ops        band    jmp  rx    ry    ctl     sel    salto
      tabla[0] = '{3'b000, 6'b011101, 3'b000, 1'b0, 3'd3, 3'd5, 3'b000, 2'b00, 1'b0};
      tabla[1] = '{3'b001, 6'b110010, 3'b000, 1'b0, 3'd6, 3'd2, 3'b001, 2'b00, 1'b0};
      tabla[2] = '{3'b010, 6'b001111, 3'b000, 1'b0, 3'd1, 3'd7, 3'b010, 2'b00, 1'b0};
      tabla[3] = '{3'b011, 6'b101000, 3'b000, 1'b0, 3'd5, 3'd0, 3'b011, 2'b00, 1'b0};
      tabla[4] = '{3'b110, 6'b100011, 3'b000, 1'b0, 3'd4, 3'd3, 3'b000, 2'b10, 1'b0};
      tabla[5] = '{3'b111, 6'b000001, 3'b000, 1'b1, 3'd0, 3'd1, 3'b000, 2'b00, 1'b0};
      tabla[6] = '{3'b111, 6'b000001, 3'b001, 1'b1, 3'd0, 3'd1, 3'b000, 2'b00, 1'b1};
      tabla[7] = '{3'b111, 6'b010000, 3'b000, 1'b1, 3'd2, 3'd0, 3'b000, 2'b00, 1'b1};
      tabla[8] = '{3'b111, 6'b000100, 3'b111, 1'b1, 3'd0, 3'd4, 3'b000, 2'b00, 1'b0};
      tabla[9] = '{3'b111, 6'b000011, 3'b100, 1'b1, 3'd0, 3'd3, 3'b000, 2'b00, 1'b1};

      rst = 1'b0; valid = 1'b0; valid2 = 1'b0; op = '0; op2 = '0;
      ops = '0; band = '0; mem_lista = 1'b0;
      repeat (2) @(negedge clk);
      valid = 1'b1;
      #1;
      chk("rst.accept", acc, 0);
      chk("rst.est", est, 0);
      chk("rst.hab", hab, 0);
      chk("rst.le", le, 0);
      chk("rst.err", err, 0);
      chk("rst.rx", rx, 0);
      valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(tabla[i], i);

      // LOAD: ready after 4 wait cycles -> 5 read cycles, then WB from memory.
      to_mem(3'b100, 6'b010001);
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("ld.mem_est%0d", c), est, 3);
         chk($sformatf("ld.le%0d", c), le, 2'b01);
         chk($sformatf("ld.hab%0d", c), hab, 0);
         if (c == 4) mem_lista = 1'b1;
         @(negedge clk);
      end
      mem_lista = 1'b0;
      chk("ld.wb_est", est, 4);
      chk("ld.wb_hab", hab, 1);
      chk("ld.wb_sel", sel, 2'b01);
      chk("ld.wb_addr", waddr, 2);
      chk("ld.wb_le", le, 0);
      @(negedge clk);
      chk("ld.end_est", est, 0);

      // STORE with immediate ready: one write cycle, no write-back.
      to_mem(3'b101, 6'b001010);
      chk("st.le", le, 2'b10);
      mem_lista = 1'b1;
      @(negedge clk);
      mem_lista = 1'b0;
      chk("st.end_est", est, 0);
      chk("st.hab", hab, 0);
      chk("st.err", err, 0);

      // STORE never ready: 15 MEM cycles then error, no write-back.
      to_mem(3'b101, 6'b000000);
      for (int c = 0; c < 15; c++) begin
         if (est != 3 || le != 2'b10 || hab != 0 || err != 0)
            chk($sformatf("to.mem%0d", c), {est, le, hab, err}, {3'd3, 2'b10, 1'b0, 1'b0});
         @(negedge clk);
      end
      total++;
      chk("to.est", est, 0);
      chk("to.err", err, 1);
      chk("to.hab", hab, 0);
      run_vec(tabla[0], 10);
      chk("to.err_sticky", err, 1);

      // Illegal 4-bit opcode on the wide instance.
      op2 = 4'b1010; valid2 = 1'b1;
      #1 chk("il.accept", acc2, 1);
      @(negedge clk);
      valid2 = 1'b0;
      chk("il.dec_est", est2, 1);
      chk("il.dec_err", err2, 0);
      @(negedge clk);
      chk("il.est", est2, 0);
      chk("il.err", err2, 1);
      chk("il.hab", hab2, 0);
      chk("il.le", le2, 0);

      // Reset in the middle of a LOAD's MEM phase.
      to_mem(3'b100, 6'b011001);
      chk("rm.le_pre", le, 2'b01);
      #2 rst = 1'b0;
      #1;
      chk("rm.est", est, 0);
      chk("rm.le", le, 0);
      chk("rm.rx", rx, 0);
      chk("rm.err", err, 0);
      chk("rm.err2", err2, 0);
      valid = 1'b1; mem_lista = 1'b1;
      #1 chk("rm.accept", acc, 0);
      @(negedge clk);
      valid = 1'b0; mem_lista = 1'b0; rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rm.hab%0d", c), hab, 0);
         chk($sformatf("rm.idle%0d", c), est, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
